imm_splitter: RTL and testbench

- Inverse of the datapath sign-extender. It takes a 32-bit constant and emits the minimal sequence of 16-bit immediates that rebuilds it in a register.
- Sequences: a single ADDI (sign-extended), a single LUI, or a LUI then ORI (zero-extended) pair.
- Sits between the constant source (assembler/loader stream, test sequencer) and the instruction-word builder.
- Uses valid/ready handshakes on both sides.

---
 rtl/imm_pkg.sv | 20 ++
 rtl/imm_classify.sv | 19 +
 rtl/imm_splitter.sv | 163 ++++++++++++++++
 tb/tb_imm_splitter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// imm_pkg: shared definitions for the immediate splitter and its helpers.
//   - Immediate kind encodings carried on out_kind.
//   - Splitter FSM state encoding.
//   - Field widths for the immediate and the full constant word.
package imm_pkg;

  localparam int unsigned IMM_W  = 16;
  localparam int unsigned WORD_W = 32;

  localparam logic [1:0] KIND_ADDI = 2'd0;
  localparam logic [1:0] KIND_LUI  = 2'd1;
  localparam logic [1:0] KIND_ORI  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT1 = 2'd1,
    ST_BEAT2 = 2'd2
  } imm_state_t;

endpackage

// File: rtl/imm_classify.sv
// imm_classify: combinational classification of a 32-bit constant.
//   i_word   : constant to classify
//   o_fits   : i_word[31:15] all zeros or all ones (single sign-extended ADDI)
//   o_lozero : low half is zero (single LUI suffices when o_fits is low)
module imm_classify
  import imm_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  output logic              o_fits,
  output logic              o_lozero
);

  logic [WORD_W-IMM_W:0] w_top;

  assign w_top    = i_word[WORD_W-1:IMM_W-1];
  assign o_fits   = (w_top == '0) || (w_top == '1);
  assign o_lozero = (i_word[IMM_W-1:0] == '0);

endmodule

// File: rtl/imm_splitter.sv
// imm_splitter: splits a 32-bit constant into the minimal ADDI / LUI /
// LUI+ORI immediate sequence, with valid/ready handshakes on both sides.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid/in_ready   : constant handshake, in_data is the constant
//   out_valid/out_ready : immediate beat handshake
//   out_imm, out_kind   : 16-bit immediate and its kind (0 ADDI, 1 LUI, 2 ORI)
//   out_last            : final beat of the current constant
// Optional feature, macro IMM_SPLITTER_STATS_EN: adds saturating per-class
// counters stat_fits, stat_lozero, stat_pair (CNT_W bits each).
module imm_splitter
  import imm_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IMM_W-1:0]  out_imm,
  output logic [1:0]        out_kind,
  output logic              out_last
`ifdef IMM_SPLITTER_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_fits,
  output logic [CNT_W-1:0]  stat_lozero,
  output logic [CNT_W-1:0]  stat_pair
`endif
);

  if (CNT_W == 0) begin : g_cnt_w_check
    $error("imm_splitter: CNT_W must be at least 1");
  end

  imm_state_t        r_state;
  logic [WORD_W-1:0] r_data;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [IMM_W-1:0]  r_out_imm;
  logic [1:0]        r_out_kind;
  logic              r_out_last;

  logic w_in_fits;
  logic w_in_lozero;
  logic w_cap_fits;
  logic w_cap_lozero;
  logic w_accept;

  // Incoming constant decides the first beat.
  imm_classify u_classify_in (
    .i_word   (in_data),
    .o_fits   (w_in_fits),
    .o_lozero (w_in_lozero)
  );

  // Captured constant decides whether an ORI beat follows the LUI.
  imm_classify u_classify_cap (
    .i_word   (r_data),
    .o_fits   (w_cap_fits),
    .o_lozero (w_cap_lozero)
  );

  assign w_accept = (r_state == ST_IDLE) && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_data      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_imm   <= '0;
      r_out_kind  <= KIND_ADDI;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_data      <= in_data;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_BEAT1;
            if (w_in_fits) begin
              r_out_imm  <= in_data[IMM_W-1:0];
              r_out_kind <= KIND_ADDI;
              r_out_last <= 1'b1;
            end else begin
              r_out_imm  <= in_data[WORD_W-1:IMM_W];
              r_out_kind <= KIND_LUI;
              r_out_last <= w_in_lozero;
            end
          end
        end

        ST_BEAT1: begin
          if (out_ready) begin
            if (!w_cap_fits && !w_cap_lozero) begin
              r_out_imm  <= r_data[IMM_W-1:0];
              r_out_kind <= KIND_ORI;
              r_out_last <= 1'b1;
              r_state    <= ST_BEAT2;
            end else begin
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end
        end

        ST_BEAT2: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_imm   = r_out_imm;
  assign out_kind  = r_out_kind;
  assign out_last  = r_out_last;

`ifdef IMM_SPLITTER_STATS_EN
  logic [CNT_W-1:0] r_stat_fits;
  logic [CNT_W-1:0] r_stat_lozero;
  logic [CNT_W-1:0] r_stat_pair;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_fits   <= '0;
      r_stat_lozero <= '0;
      r_stat_pair   <= '0;
    end else if (w_accept) begin
      if (w_in_fits) begin
        if (r_stat_fits != '1) r_stat_fits <= r_stat_fits + 1'b1;
      end else if (w_in_lozero) begin
        if (r_stat_lozero != '1) r_stat_lozero <= r_stat_lozero + 1'b1;
      end else begin
        if (r_stat_pair != '1) r_stat_pair <= r_stat_pair + 1'b1;
      end
    end
  end

  assign stat_fits   = r_stat_fits;
  assign stat_lozero = r_stat_lozero;
  assign stat_pair   = r_stat_pair;
`else
  logic w_unused_accept;
  assign w_unused_accept = w_accept;
`endif

endmodule

// File: tb/tb_imm_splitter.sv
// tb_imm_splitter: randomized self-checking bench for imm_splitter against
// an arithmetic reference model of the ADDI / LUI / LUI+ORI rules.
module tb_imm_splitter;

  localparam logic [1:0] K_ADDI = 2'd0;
  localparam logic [1:0] K_LUI  = 2'd1;
  localparam logic [1:0] K_ORI  = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_imm;
  logic [1:0]  out_kind;
  logic        out_last;

  always #5 clk = ~clk;

`ifdef IMM_SPLITTER_STATS_EN
  logic [15:0] stat_fits, stat_lozero, stat_pair;
  logic        s_valid, s_ready, s_out_valid, s_out_last;
  logic        s_out_ready;
  logic [31:0] s_data;
  logic [15:0] s_imm;
  logic [1:0]  s_kind;
  logic [1:0]  s_fits, s_lozero, s_pair;
`endif

  imm_splitter #(.CNT_W(16)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_kind  (out_kind),
    .out_last  (out_last)
`ifdef IMM_SPLITTER_STATS_EN
    ,
    .stat_fits   (stat_fits),
    .stat_lozero (stat_lozero),
    .stat_pair   (stat_pair)
`endif
  );

`ifdef IMM_SPLITTER_STATS_EN
  imm_splitter #(.CNT_W(2)) u_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (s_valid),
    .in_ready    (s_ready),
    .in_data     (s_data),
    .out_valid   (s_out_valid),
    .out_ready   (s_out_ready),
    .out_imm     (s_imm),
    .out_kind    (s_kind),
    .out_last    (s_out_last),
    .stat_fits   (s_fits),
    .stat_lozero (s_lozero),
    .stat_pair   (s_pair)
  );
`endif

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  kind;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned m_fits  = 0;
  int unsigned m_lozero = 0;
  int unsigned m_pair  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: the value fits a sign-extended 16-bit immediate iff it lies in
  // [-32768, 32767]; otherwise a zero low half needs only the upper half.
  task automatic build_expect(input logic [31:0] v);
    int sv;
    sv = $signed(v);
    exp_q.delete();
    if (sv >= -32768 && sv <= 32767) begin
      exp_q.push_back('{imm: 16'(v % 65536), kind: K_ADDI, last: 1'b1});
      m_fits++;
    end else if (v % 65536 == 0) begin
      exp_q.push_back('{imm: 16'(v / 65536), kind: K_LUI, last: 1'b1});
      m_lozero++;
    end else begin
      exp_q.push_back('{imm: 16'(v / 65536), kind: K_LUI, last: 1'b0});
      exp_q.push_back('{imm: 16'(v % 65536), kind: K_ORI, last: 1'b1});
      m_pair++;
    end
  endtask

  task automatic wait_in_ready();
    int unsigned waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
  endtask

  task automatic send(input logic [31:0] v, input int unsigned stall, input bit offer);
    logic [31:0] recon;
    int unsigned nb;
    wait_in_ready();
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    in_data  = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    build_expect(v);
    check("first_valid", 32'(out_valid), 32'd1);
    check("busy_ready", 32'(in_ready), 32'd0);
    if (offer) begin
      in_valid = 1'b1;
      in_data  = 32'h0000_0055;
    end
    recon = '0;
    nb = exp_q.size();
    for (int unsigned i = 0; i < nb; i++) begin
      for (int unsigned s = 0; s < stall; s++) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_imm", 32'(out_imm), 32'(exp_q[i].imm));
        check("hold_kind", 32'(out_kind), 32'(exp_q[i].kind));
        check("hold_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
      end
      check("beat_valid", 32'(out_valid), 32'd1);
      check("beat_imm", 32'(out_imm), 32'(exp_q[i].imm));
      check("beat_kind", 32'(out_kind), 32'(exp_q[i].kind));
      check("beat_last", 32'(out_last), 32'(exp_q[i].last));
      case (out_kind)
        K_ADDI:  recon = {{16{out_imm[15]}}, out_imm};
        K_LUI:   recon = {out_imm, 16'h0000};
        default: recon = recon | {16'h0000, out_imm};
      endcase
      if (i == nb - 1) in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    check("recon", recon, v);
    check("done_valid", 32'(out_valid), 32'd0);
    check("done_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] v;
    logic [31:0] edges[7];
    edges = '{32'h0000_7FFF, 32'h0000_8000, 32'hFFFF_8000, 32'hFFFF_7FFF,
              32'h0000_0000, 32'hFFFF_FFFF, 32'h0001_0000};
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef IMM_SPLITTER_STATS_EN
    s_valid = 1'b0; s_data = '0; s_out_ready = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_imm", 32'(out_imm), 32'd0);
    check("rst_kind", 32'(out_kind), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef IMM_SPLITTER_STATS_EN
    check("stat_fits0", 32'(stat_fits), 32'd0);
    send(32'h0000_0001, 0, 1'b0);
    send(32'h0005_0000, 0, 1'b0);
    send(32'hCAFE_BABE, 0, 1'b0);
    check("stat_fits", 32'(stat_fits), 32'd1);
    check("stat_lozero", 32'(stat_lozero), 32'd1);
    check("stat_pair", 32'(stat_pair), 32'd1);
`endif

    send(32'h0000_000A, 0, 1'b0);
    send(32'hFFFF_FFFA, 0, 1'b0);
    send(32'hFFFF_8000, 0, 1'b0);
    send(32'h0000_8000, 0, 1'b0);
    send(32'h1234_0000, 0, 1'b0);
    send(32'hDEAD_BEEF, 5, 1'b1);

    // Reset while the ORI beat is pending.
    wait_in_ready();
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2_kind", 32'(out_kind), 32'(K_ORI));
    check("b2_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_fits = 0; m_lozero = 0; m_pair = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("no_ori", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;
    send(32'h0000_7FFF, 0, 1'b0);

`ifdef IMM_SPLITTER_STATS_EN
    for (int i = 0; i < 4; i++) begin
      for (int w = 0; w < 20 && !s_ready; w++) begin
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = 32'(i + 1);
      @(posedge clk); #1;
      s_valid = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("sat_fits", 32'(s_fits), 32'd3);
`endif

    for (int n = 0; n < 60; n++) begin
      r = $urandom;
      case ($urandom_range(0, 3))
        0: v = {{16{r[15]}}, r[15:0]};
        1: v = {r[15:0], 16'h0000};
        2: v = r;
        default: v = edges[$urandom_range(0, 6)];
      endcase
      send(v, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

`ifdef IMM_SPLITTER_STATS_EN
    check("final_fits", 32'(stat_fits), m_fits);
    check("final_lozero", 32'(stat_lozero), m_lozero);
    check("final_pair", 32'(stat_pair), m_pair);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
